can_tx_dlc_packer: RTL and testbench
====================================

# can_tx_dlc_packer

Transmit-side payload packer for the CAN/CAN FD controller. It buffers one message payload from the host TX path and derives the 4-bit DLC from the byte count, rounding up to the next legal FD length. It then streams the payload to the bit-level transmitter, appending padding bytes up to the encoded length. It is the inverse of the receive-side DLC-to-length decoding and sits between the host TX buffer and the transmit serializer.

## Interface
- PAD_BYTE, 8'hCC, value emitted for FD padding bytes
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- fd_frame_in  in  1  frame type (1 = FD), sampled with first byte or zero_len_in
- byte_in  in  8  payload byte from host
- byte_valid_in  in  1  byte_in valid
- byte_last_in  in  1  byte_in is last payload byte
- byte_ready_out  out  1  packer accepts byte (handshake = valid & ready)
- zero_len_in  in  1  request zero-length frame (single-cycle pulse)
- dlc_out  out  4  encoded DLC
- data_len_out  out  7  padded byte count (0..64)
- dlc_valid_out  out  1  one-cycle pulse: dlc_out/data_len_out/overflow_out updated
- overflow_out  out  1  payload exceeded maximum; excess bytes dropped
- data_out  out  8  payload/padding byte to serializer
- data_valid_out  out  1  data_out valid
- data_ready_in  in  1  serializer accepts byte
- data_last_out  out  1  data_out is final byte of frame

## Operation
- 64 x 8 payload buffer, 7-bit byte counter cnt, latched fd flag, FSM: IDLE, FILL, SIZE, DRAIN.
- IDLE: byte_ready_out=1. Accepted byte -> buf[0], cnt=1, latch fd_frame_in; -> SIZE if byte_last_in, else FILL. zero_len_in without byte_valid_in -> cnt=0, latch fd, -> SIZE. Byte and zero_len_in together: byte wins, zero_len_in ignored.
- FILL: byte_ready_out=1; accepted byte -> buf[cnt], cnt++. Max = 64 (FD) / 8 (classic). Once cnt = max, further bytes are still accepted and discarded, and the overflow flag is set. byte_last_in -> SIZE.
- SIZE (1 cycle): byte_ready_out=0.
  - Classic: dlc = cnt (0..8).
  - FD: cnt 0..8 -> dlc=cnt; 9-12 -> 9; 13-16 -> 10; 17-20 -> 11; 21-24 -> 12; 25-32 -> 13; 33-48 -> 14; 49-64 -> 15.
  - len = decoded length of dlc.
  - Register dlc_out, data_len_out, overflow_out. Pulse dlc_valid_out.
  - Next state: DRAIN if len>0, else IDLE.
- DRAIN: byte_ready_out=0; data_valid_out=1; data_out = buf[idx] if idx<cnt, else PAD_BYTE. idx advances on data_valid_out & data_ready_in. data_last_out = (idx == len-1). Handshake on last byte -> IDLE.
- data_out, data_last_out held stable while data_valid_out=1 and data_ready_in=0.
- zero_len_in, byte_valid_in ignored outside IDLE/FILL. zero_len_in ignored in FILL.
- dlc_out, data_len_out, overflow_out hold until the next SIZE.

## Timing
- Reset: state IDLE, cnt=0, idx=0. All outputs 0, including byte_ready_out while rst is high. byte_ready_out=1 in the first cycle after rst deasserts.
- Last byte (or zero_len_in) accepted in cycle N -> SIZE in N+1 -> dlc_valid_out=1 and registered outputs valid in N+2.
- For len>0, data_valid_out=1 from cycle N+2, so first data byte coincides with dlc_valid_out.
- Full-throughput drain: one byte per cycle while data_ready_in=1.
- After the final drain handshake in cycle M, IDLE in M+1, with byte_ready_out=1.
- Zero-length frame: IDLE again in N+2; data_valid_out never asserted.
- rst mid-frame (any state): next cycle IDLE. Buffer contents and counters discarded, data_valid_out=0, no dlc_valid_out.

## Test plan
- Classic, 5 bytes 0x11..0x15 -> dlc_out=5, data_len_out=5, overflow_out=0. Bytes 0x11..0x15 out, data_last_out on 0x15.
- FD, 10 bytes 0x01..0x0A -> dlc_out=9, data_len_out=12. Out: 0x01..0x0A, then 0xCC, 0xCC; data_last_out on 12th byte.
- FD, 64 bytes -> dlc_out=15, len 64, overflow_out=0. FD, 65 bytes -> overflow_out=1, dlc_out=15, only the first 64 bytes out.
- Classic, 10 bytes -> overflow_out=1, dlc_out=8, bytes 1..8 out, data_last_out on 8th.
- zero_len_in with fd=1 -> dlc_out=0, data_len_out=0, no data_valid_out, byte_ready_out=1 two cycles later. FD 20-byte frame with data_ready_in toggling each cycle -> 20 bytes out in order, data_out stable while stalled, dlc_out=11.
- rst asserted during DRAIN of an FD 16-byte frame -> data_valid_out=0 next cycle. A following classic 1-byte frame 0xA5 -> dlc_out=1, single byte 0xA5 with data_last_out.

Source files
------------

// File: rtl/can_tx_dlc_packer.sv
// can_tx_dlc_packer: buffers a CAN/CAN FD payload, derives DLC and streams it padded to the encoded length
module can_tx_dlc_packer #(
  parameter logic [7:0] PAD_BYTE = 8'hCC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fd_frame_in,
  input  logic [7:0] byte_in,
  input  logic       byte_valid_in,
  input  logic       byte_last_in,
  output logic       byte_ready_out,
  input  logic       zero_len_in,
  output logic [3:0] dlc_out,
  output logic [6:0] data_len_out,
  output logic       dlc_valid_out,
  output logic       overflow_out,
  output logic [7:0] data_out,
  output logic       data_valid_out,
  input  logic       data_ready_in,
  output logic       data_last_out
);
  typedef enum logic [1:0] {IDLE, FILL, SIZE, DRAIN} state_t;
  state_t     state;
  logic [7:0] mem [64];
  logic [6:0] cnt, idx, max_len, len_dec;
  logic [3:0] dlc_enc;
  logic       fd, ovf;
  assign byte_ready_out = ~rst & (state == IDLE || state == FILL);
  assign max_len        = fd ? 7'd64 : 7'd8;
  assign data_valid_out = state == DRAIN;
  assign data_out       = data_valid_out ? (idx < cnt ? mem[idx[5:0]] : PAD_BYTE) : 8'h00;
  assign data_last_out  = data_valid_out & (idx == data_len_out - 7'd1);
  // round the byte count up to the next legal FD length and decode it back
  always_comb begin
    dlc_enc = cnt <= 7'd8  ? cnt[3:0] :
              cnt <= 7'd12 ? 4'd9  :
              cnt <= 7'd16 ? 4'd10 :
              cnt <= 7'd20 ? 4'd11 :
              cnt <= 7'd24 ? 4'd12 :
              cnt <= 7'd32 ? 4'd13 :
              cnt <= 7'd48 ? 4'd14 : 4'd15;
    len_dec = dlc_enc <= 4'd8  ? {3'd0, dlc_enc} :
              dlc_enc == 4'd9  ? 7'd12 :
              dlc_enc == 4'd10 ? 7'd16 :
              dlc_enc == 4'd11 ? 7'd20 :
              dlc_enc == 4'd12 ? 7'd24 :
              dlc_enc == 4'd13 ? 7'd32 :
              dlc_enc == 4'd14 ? 7'd48 : 7'd64;
  end
  // payload store; bytes beyond the frame maximum are dropped
  always_ff @(posedge clk)
    if (byte_valid_in && byte_ready_out && (state == IDLE || cnt < max_len))
      mem[state == IDLE ? 6'd0 : cnt[5:0]] <= byte_in;
  // frame sequencing: collect, size, then drain with padding
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      fd            <= 1'b0;
      ovf           <= 1'b0;
      dlc_out       <= '0;
      data_len_out  <= '0;
      overflow_out  <= 1'b0;
      dlc_valid_out <= 1'b0;
    end else begin
      dlc_valid_out <= state == SIZE;
      case (state)
        IDLE:
          if (byte_valid_in) begin
            cnt   <= 7'd1;
            fd    <= fd_frame_in;
            ovf   <= 1'b0;
            state <= byte_last_in ? SIZE : FILL;
          end else if (zero_len_in) begin
            cnt   <= '0;
            fd    <= fd_frame_in;
            ovf   <= 1'b0;
            state <= SIZE;
          end
        FILL:
          if (byte_valid_in) begin
            if (cnt < max_len) cnt <= cnt + 7'd1;
            else ovf <= 1'b1;
            if (byte_last_in) state <= SIZE;
          end
        SIZE: begin
          dlc_out      <= dlc_enc;
          data_len_out <= len_dec;
          overflow_out <= ovf;
          idx          <= '0;
          state        <= len_dec != 7'd0 ? DRAIN : IDLE;
        end
        DRAIN:
          if (data_ready_in) begin
            idx <= idx + 7'd1;
            if (data_last_out) state <= IDLE;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_can_tx_dlc_packer.sv
// tb_can_tx_dlc_packer: randomized directed bench against a length-table reference model
`timescale 1ns/1ps
module tb_can_tx_dlc_packer;
  logic       clk = 1'b0, rst = 1'b1;
  logic       fd_frame_in = 1'b0, byte_valid_in = 1'b0, byte_last_in = 1'b0;
  logic       zero_len_in = 1'b0, data_ready_in = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_ready_out, dlc_valid_out, overflow_out, data_valid_out, data_last_out;
  logic [3:0] dlc_out;
  logic [6:0] data_len_out;
  logic [7:0] data_out;
  int         passes = 0, fails = 0, total = 0;
  logic [7:0] payload [70];
  int         legal [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 12, 16, 20, 24, 32, 48, 64};

  can_tx_dlc_packer dut (
    .clk(clk), .rst(rst), .fd_frame_in(fd_frame_in), .byte_in(byte_in),
    .byte_valid_in(byte_valid_in), .byte_last_in(byte_last_in), .byte_ready_out(byte_ready_out),
    .zero_len_in(zero_len_in), .dlc_out(dlc_out), .data_len_out(data_len_out),
    .dlc_valid_out(dlc_valid_out), .overflow_out(overflow_out), .data_out(data_out),
    .data_valid_out(data_valid_out), .data_ready_in(data_ready_in), .data_last_out(data_last_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame(input bit fd, input int n, input int mode, input int stop_at);
    int max, keep, d, len, k, cyc;
    bit ovf;
    max  = fd ? 64 : 8;
    keep = n < max ? n : max;
    ovf  = n > max;
    d    = 0;
    while (legal[d] < keep) d++;
    len  = legal[d];
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        byte_valid_in = 1'b0;
        zero_len_in   = 1'b0;
        @(negedge clk);
        chk("ready_gap", {31'd0, byte_ready_out}, 1);
      end
      byte_valid_in = 1'b1;
      byte_in       = payload[i];
      byte_last_in  = i == n - 1;
      fd_frame_in   = i == 0 ? fd : 1'($urandom);
      zero_len_in   = 1'($urandom);
      chk("byte_ready", {31'd0, byte_ready_out}, 1);
      @(negedge clk);
    end
    byte_valid_in = 1'b0;
    byte_last_in  = 1'b0;
    zero_len_in   = 1'b0;
    chk("size_ready", {31'd0, byte_ready_out}, 0);
    chk("size_dv", {31'd0, data_valid_out}, 0);
    chk("size_dlcv", {31'd0, dlc_valid_out}, 0);
    zero_len_in   = 1'($urandom);
    byte_valid_in = 1'($urandom);
    @(negedge clk);
    zero_len_in   = 1'b0;
    byte_valid_in = 1'b0;
    chk("dlc_valid", {31'd0, dlc_valid_out}, 1);
    chk("dlc", {28'd0, dlc_out}, d);
    chk("data_len", {25'd0, data_len_out}, len);
    chk("overflow", {31'd0, overflow_out}, {31'd0, ovf});
    k   = 0;
    cyc = 0;
    while (k < len && k != stop_at && cyc < 500) begin
      chk("dv", {31'd0, data_valid_out}, 1);
      chk("data", {24'd0, data_out}, {24'd0, k < keep ? payload[k] : 8'hCC});
      chk("last", {31'd0, data_last_out}, {31'd0, k == len - 1});
      chk("drain_ready", {31'd0, byte_ready_out}, 0);
      if (cyc > 0) chk("dlcv_low", {31'd0, dlc_valid_out}, 0);
      data_ready_in = mode == 0 ? 1'($urandom) : mode == 1 ? 1'(cyc % 2) : 1'b1;
      byte_valid_in = 1'($urandom);
      @(negedge clk);
      if (data_ready_in) k++;
      cyc++;
    end
    data_ready_in = 1'b0;
    byte_valid_in = 1'b0;
    if (cyc >= 500) chk("drain_timeout", k, len);
    if (stop_at < 0) begin
      chk("idle_ready", {31'd0, byte_ready_out}, 1);
      chk("idle_dv", {31'd0, data_valid_out}, 0);
    end
  endtask

  task automatic zero(input bit fd);
    zero_len_in   = 1'b1;
    fd_frame_in   = fd;
    byte_valid_in = 1'b0;
    chk("zl_ready", {31'd0, byte_ready_out}, 1);
    @(negedge clk);
    zero_len_in = 1'b0;
    chk("zl_size_ready", {31'd0, byte_ready_out}, 0);
    @(negedge clk);
    chk("zl_dlcv", {31'd0, dlc_valid_out}, 1);
    chk("zl_dlc", {28'd0, dlc_out}, 0);
    chk("zl_len", {25'd0, data_len_out}, 0);
    chk("zl_ovf", {31'd0, overflow_out}, 0);
    chk("zl_dv", {31'd0, data_valid_out}, 0);
    chk("zl_ready2", {31'd0, byte_ready_out}, 1);
    @(negedge clk);
    chk("zl_dv2", {31'd0, data_valid_out}, 0);
    chk("zl_dlcv2", {31'd0, dlc_valid_out}, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, byte_ready_out}, 0);
    chk({tag, "_dv"}, {31'd0, data_valid_out}, 0);
    chk({tag, "_dlcv"}, {31'd0, dlc_valid_out}, 0);
    chk({tag, "_data"}, {24'd0, data_out}, 0);
    chk({tag, "_last"}, {31'd0, data_last_out}, 0);
    chk({tag, "_dlc"}, {28'd0, dlc_out}, 0);
    chk({tag, "_len"}, {25'd0, data_len_out}, 0);
    chk({tag, "_ovf"}, {31'd0, overflow_out}, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", {31'd0, byte_ready_out}, 1);
    for (int i = 0; i < 5; i++) payload[i] = 8'h11 + 8'(i);
    frame(1'b0, 5, 2, -1);
    for (int i = 0; i < 10; i++) payload[i] = 8'h01 + 8'(i);
    frame(1'b1, 10, 2, -1);
    for (int i = 0; i < 70; i++) payload[i] = 8'($urandom);
    frame(1'b1, 64, 0, -1);
    frame(1'b1, 65, 2, -1);
    frame(1'b0, 10, 0, -1);
    zero(1'b1);
    frame(1'b1, 20, 1, -1);
    zero(1'b0);
    repeat (10) begin
      bit fd;
      fd = 1'($urandom);
      for (int i = 0; i < 70; i++) payload[i] = 8'($urandom);
      frame(fd, $urandom_range(1, fd ? 70 : 12), $urandom_range(0, 2), -1);
    end
    for (int i = 0; i < 16; i++) payload[i] = 8'($urandom);
    frame(1'b1, 16, 2, 5);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", {31'd0, byte_ready_out}, 1);
    chk("mid_rst_dv", {31'd0, data_valid_out}, 0);
    chk("mid_rst_dlcv", {31'd0, dlc_valid_out}, 0);
    payload[0] = 8'hA5;
    frame(1'b0, 1, 2, -1);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
